// File: rtl/axi_write.sv
// axi_write: AXI-Stream to fixed-length AXI4 INCR write bursts, addresses cycling through a ring of NUM_BURSTS.
module axi_write #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    AW_LEN     = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    NUM_BURSTS = 1
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_aresetn,
    input  logic [DATA_WIDTH-1:0]   S_WR_tdata,
    input  logic                    S_WR_tvalid,
    input  logic                    S_WR_tlast,
    output logic                    S_WR_tready,
    output logic                    m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic                    m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic                    o_wr_done,
    output logic                    o_len_err,
    output logic                    o_bresp_err
);
    localparam int CW = AW_LEN > 1 ? $clog2(AW_LEN) : 1;
    localparam int IW = NUM_BURSTS > 1 ? $clog2(NUM_BURSTS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(AW_LEN - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BURSTS - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(AW_LEN * DATA_WIDTH / 8);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, WR_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    awvalid_q, awvalid_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    len_err_q, len_err_d;
    logic                    bresp_err_q, bresp_err_d;
    logic                    last_beat, w_hs, wrap;
    logic                    unused_bid;

    assign unused_bid = m_axi_bid;
    assign last_beat  = cnt_q == LAST_BEAT;
    assign w_hs       = state_q == WR_DATA && S_WR_tvalid && m_axi_wready;
    assign wrap       = idx_q == LAST_IDX;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        len_err_d   = len_err_q;
        bresp_err_d = bresp_err_q;
        case (state_q)
            IDLE: if (S_WR_tvalid) begin
                state_d   = WR_ADDR;
                awvalid_d = 1'b1;
            end
            WR_ADDR: if (m_axi_awready) begin
                state_d   = WR_DATA;
                awvalid_d = 1'b0;
            end
            WR_DATA: if (w_hs) begin
                // A burst always ends at AW_LEN beats; tlast only feeds the error flag.
                cnt_d     = last_beat ? '0 : cnt_q + 1'b1;
                len_err_d = len_err_q | (S_WR_tlast != last_beat);
                state_d   = last_beat ? WR_RESP : WR_DATA;
            end
            WR_RESP: if (m_axi_bvalid) begin
                state_d     = WR_DONE;
                bresp_err_d = bresp_err_q | (m_axi_bresp != 2'b00);
            end
            WR_DONE: begin
                state_d  = IDLE;
                idx_d    = wrap ? '0 : idx_q + 1'b1;
                awaddr_d = wrap ? BASE_ADDR : awaddr_q + STRIDE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            awaddr_q    <= BASE_ADDR;
            idx_q       <= '0;
            cnt_q       <= '0;
            len_err_q   <= 1'b0;
            bresp_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            len_err_q   <= len_err_d;
            bresp_err_q <= bresp_err_d;
        end
    end

    assign m_axi_awid    = 1'b0;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'(AW_LEN - 1);
    assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = S_WR_tdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = state_q == WR_DATA && S_WR_tvalid;
    assign m_axi_wlast   = state_q == WR_DATA && last_beat;
    assign S_WR_tready   = state_q == WR_DATA && m_axi_wready;
    assign m_axi_bready  = state_q == WR_RESP;
    assign o_wr_done     = state_q == WR_DONE;
    assign o_len_err     = len_err_q;
    assign o_bresp_err   = bresp_err_q;
endmodule

// File: tb/tb_axi_write.sv
// tb_axi_write: random-backpressure bench for axi_write against a burst-level reference model.
module tb_axi_write;
    localparam int AW = 32, DW = 64, LEN = 4, NB = 3;
    localparam int BYTES = LEN * DW / 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] S_WR_tdata;
    logic S_WR_tvalid, S_WR_tlast, S_WR_tready;
    logic m_axi_awid, m_axi_awlock, m_axi_awvalid, m_axi_awready;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0] m_axi_awlen;
    logic [2:0] m_axi_awsize, m_axi_awprot;
    logic [1:0] m_axi_awburst, m_axi_bresp;
    logic [3:0] m_axi_awcache, m_axi_awqos;
    logic [DW-1:0] m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic m_axi_bid, m_axi_bvalid, m_axi_bready;
    logic o_wr_done, o_len_err, o_bresp_err;

    always #5 clk = ~clk;

    axi_write #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AW_LEN(LEN), .BASE_ADDR('0), .NUM_BURSTS(NB)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .S_WR_tdata(S_WR_tdata), .S_WR_tvalid(S_WR_tvalid), .S_WR_tlast(S_WR_tlast), .S_WR_tready(S_WR_tready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .o_wr_done(o_wr_done), .o_len_err(o_len_err), .o_bresp_err(o_bresp_err)
    );

    int n_vec = 0, n_err = 0;
    logic [DW:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    int aw_n, beat, done_cnt, aw_delay, b_wait;
    bit in_data, resp, b_pending, done_exp, tv_hold, len_err_exp, bresp_err_exp, aw_seen;
    logic [1:0] bresp_sel;
    logic [AW-1:0] aw_hold_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        src_q.delete();
        exp_q.delete();
        aw_n = 0; beat = 0; done_cnt = 0; aw_delay = 0; b_wait = 0;
        in_data = 0; resp = 0; b_pending = 0; done_exp = 0; tv_hold = 0;
        len_err_exp = 0; bresp_err_exp = 0; aw_seen = 0;
    endtask

    task automatic drive_idle();
        S_WR_tvalid = 0; S_WR_tlast = 0; S_WR_tdata = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_wlast", m_axi_wlast, 0);
        check("rst_bready", m_axi_bready, 0);
        check("rst_tready", S_WR_tready, 0);
        check("rst_done", o_wr_done, 0);
        check("rst_len_err", o_len_err, 0);
        check("rst_bresp_err", o_bresp_err, 0);
        check("rst_awaddr", m_axi_awaddr, 0);
    endtask

    task automatic push_burst(input logic [DW-1:0] d0, input int tlast_pos);
        for (int b = 0; b < LEN; b++) begin
            src_q.push_back({b == tlast_pos, d0 + DW'(b)});
            exp_q.push_back(d0 + DW'(b));
        end
    endtask

    task automatic step();
        bit aw_hs, w_hs, b_hs;
        @(negedge clk);
        if (!tv_hold) begin
            S_WR_tvalid = src_q.size() > 0 && $urandom_range(3) != 0;
            if (S_WR_tvalid) {S_WR_tlast, S_WR_tdata} = src_q[0];
        end
        m_axi_awready = aw_delay == 0 && $urandom_range(1) == 1;
        m_axi_wready = $urandom_range(3) != 0;
        m_axi_bvalid = b_pending && b_wait == 0;
        m_axi_bresp = m_axi_bvalid ? bresp_sel : 2'b00;
        if (b_pending && b_wait > 0) b_wait--;
        #1;
        check("wr_done", o_wr_done, done_exp);
        check("len_err", o_len_err, len_err_exp);
        check("bresp_err", o_bresp_err, bresp_err_exp);
        check("tready", S_WR_tready, in_data && m_axi_wready);
        check("wvalid", m_axi_wvalid, in_data && S_WR_tvalid);
        check("bready", m_axi_bready, resp);
        if (in_data || resp || done_exp) check("awvalid_busy", m_axi_awvalid, 0);
        if (m_axi_awvalid) begin
            check("aw_no_wvalid", m_axi_wvalid, 0);
            check("aw_no_tready", S_WR_tready, 0);
            if (aw_seen) check("awaddr_hold", m_axi_awaddr, aw_hold_addr);
            aw_seen = 1;
            aw_hold_addr = m_axi_awaddr;
            if (aw_delay > 0) aw_delay--;
        end
        done_cnt += int'(o_wr_done);
        aw_hs = m_axi_awvalid && m_axi_awready;
        w_hs = m_axi_wvalid && m_axi_wready;
        b_hs = m_axi_bvalid && m_axi_bready;
        done_exp = b_hs;
        if (aw_hs) begin
            check("awaddr", m_axi_awaddr, AW'((aw_n % NB) * BYTES));
            check("awlen", m_axi_awlen, LEN - 1);
            aw_n++;
            in_data = 1;
            beat = 0;
            aw_seen = 0;
        end
        if (w_hs) begin
            if (exp_q.size() == 0) check("w_extra", 1, 0);
            else check("wdata", m_axi_wdata, exp_q.pop_front());
            check("wlast", m_axi_wlast, beat == LEN - 1);
            if (S_WR_tlast != (beat == LEN - 1)) len_err_exp = 1;
            beat++;
            if (beat == LEN) begin
                in_data = 0; resp = 1; b_pending = 1; beat = 0;
                b_wait = $urandom_range(3);
            end
        end
        if (S_WR_tvalid && S_WR_tready) begin
            void'(src_q.pop_front());
            tv_hold = 0;
        end else tv_hold = S_WR_tvalid;
        if (b_hs) begin
            resp = 0; b_pending = 0;
            if (m_axi_bresp != 2'b00) bresp_err_exp = 1;
        end
    endtask

    task automatic run_until(input string tag, input int target);
        for (int i = 0; i < 3000 && done_cnt < target; i++) step();
        check(tag, done_cnt, target);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        drive_idle();
        #1;
        check_reset_outputs();
        model_clear();
        bresp_sel = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        drive_idle();
        model_clear();
        bresp_sel = 0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        check("awid", m_axi_awid, 0);
        check("awlen_c", m_axi_awlen, 3);
        check("awsize", m_axi_awsize, 3);
        check("awburst", m_axi_awburst, 1);
        check("awlock", m_axi_awlock, 0);
        check("awcache", m_axi_awcache, 4'b0011);
        check("awprot", m_axi_awprot, 0);
        check("awqos", m_axi_awqos, 0);
        check("wstrb", m_axi_wstrb, 8'hff);
        @(negedge clk);
        rst_n = 1;

        src_q.push_back({1'b0, 64'h11}); src_q.push_back({1'b0, 64'h22});
        src_q.push_back({1'b0, 64'h33}); src_q.push_back({1'b1, 64'h44});
        exp_q.push_back(64'h11); exp_q.push_back(64'h22);
        exp_q.push_back(64'h33); exp_q.push_back(64'h44);
        run_until("first_burst", 1);

        for (int k = 0; k < 16; k++) push_burst(DW'(k * LEN), LEN - 1);
        run_until("pattern_bursts", 17);
        check("pattern_drained", exp_q.size(), 0);

        aw_delay = 5;
        push_burst(64'hA0, LEN - 1);
        run_until("aw_delay_burst", 18);

        bresp_sel = 2'b10;
        push_burst(64'hB0, 1);
        run_until("err_burst", 19);
        bresp_sel = 2'b00;
        push_burst(64'hC0, LEN - 1);
        run_until("after_err_burst", 20);

        push_burst(64'hD0, LEN - 1);
        for (int i = 0; i < 500 && !(in_data && beat == 2); i++) step();
        check("reach_beat2", beat, 2);
        do_reset();
        push_burst(64'hE0, LEN - 1);
        run_until("post_reset_burst", 1);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
